// File: rtl/line_fill_ctrl_pkg.sv
// Shared types and constants for the DRAM line-fill controller.
// A line is eight 32-bit words, so line addresses are 32-byte aligned.
package line_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_FILL    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

    localparam int LINE_BITS        = 256;
    localparam int WORD_BITS        = 32;
    localparam int LINE_OFFSET_BITS = 5;

    // Drop the byte offset within the line.
    function automatic logic [WORD_BITS-1:0] line_align(input logic [WORD_BITS-1:0] a);
        return {a[WORD_BITS-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/line_fill_ctrl_if.sv
// Bundle of cache-side, DRAM-side and line-buffer signals of the fill controller.
// slave = the controller, master = whoever drives the controller's inputs.
interface line_fill_ctrl_if;
    import line_fill_ctrl_pkg::*;

    logic                  req;
    logic [WORD_BITS-1:0]  req_addr;
    logic                  req_ack;
    logic                  dram_cmd;
    logic [WORD_BITS-1:0]  dram_addr;
    logic                  dram_cmd_ack;
    logic                  dram_valid;
    logic                  buf_we;
    logic [LINE_BITS-1:0]  buf_line;
    logic                  line_valid;
    logic [LINE_BITS-1:0]  line_data;
    logic [WORD_BITS-1:0]  line_addr;
    logic                  line_ready;
    logic                  busy;
    logic                  err;

    modport slave (
        input  req, req_addr, dram_cmd_ack, dram_valid, buf_line, line_ready,
        output req_ack, dram_cmd, dram_addr, buf_we, line_valid, line_data,
               line_addr, busy, err
    );

    modport master (
        output req, req_addr, dram_cmd_ack, dram_valid, buf_line, line_ready,
        input  req_ack, dram_cmd, dram_addr, buf_we, line_valid, line_data,
               line_addr, busy, err
    );

endinterface

// File: rtl/line_fill_ctrl_timer.sv
// Inter-beat idle timer: counts enabled cycles, flags the cycle that would reach TIMEOUT.
module fill_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 1'b1;
    end

    // Combinational so the expiring idle cycle itself carries the flag.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/line_fill_ctrl.sv
// Cache-miss line fill: issues a DRAM burst, steers BEATS words into the line
// buffer, then presents the assembled line until the cache takes it.
module line_fill_ctrl
    import line_fill_ctrl_pkg::*;
#(
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             dramclk,
    input  logic             reset,
    line_fill_ctrl_if.slave  bus
);

    localparam int            BW        = $clog2(BEATS) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    state_e               state, state_nx;
    logic [WORD_BITS-1:0] line_addr_q;
    logic [BW-1:0]        beat_cnt;
    logic                 req_ack_q;
    logic                 accept, beat, last_beat;
    logic                 tmr_en, tmr_expired;

    assign accept    = (state == ST_IDLE) && bus.req;
    assign beat      = (state == ST_FILL) && bus.dram_valid;
    assign last_beat = beat && (beat_cnt == LAST_BEAT);
    // A beat on the expiring cycle wins: the timer only runs on silent FILL cycles.
    assign tmr_en    = (state == ST_FILL) && !bus.dram_valid;

    fill_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (dramclk),
        .rst     (reset),
        .clear   (!tmr_en),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge dramclk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (bus.req)          state_nx = ST_CMD;
            ST_CMD:     if (bus.dram_cmd_ack) state_nx = ST_FILL;
            ST_FILL: begin
                if (last_beat)        state_nx = ST_DELIVER;
                else if (tmr_expired) state_nx = ST_IDLE;
            end
            ST_DELIVER: if (bus.line_ready)   state_nx = ST_IDLE;
            default:                          state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge dramclk or posedge reset) begin
        if (reset) begin
            line_addr_q <= '0;
            beat_cnt    <= '0;
            req_ack_q   <= 1'b0;
        end else begin
            req_ack_q <= accept;
            if (accept) line_addr_q <= line_align(bus.req_addr);
            if (state == ST_CMD) beat_cnt <= '0;
            else if (beat)       beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.req_ack    = req_ack_q;
        bus.busy       = (state != ST_IDLE);
        bus.dram_cmd   = 1'b0;
        bus.dram_addr  = '0;
        bus.buf_we     = 1'b0;
        bus.err        = 1'b0;
        bus.line_valid = 1'b0;
        bus.line_data  = '0;
        bus.line_addr  = '0;
        case (state)
            ST_CMD: begin
                bus.dram_cmd  = 1'b1;
                bus.dram_addr = line_addr_q;
            end
            ST_FILL: begin
                bus.buf_we = bus.dram_valid;
                bus.err    = tmr_expired;
            end
            ST_DELIVER: begin
                // Buffer is frozen here (buf_we low), so pass-through is stable.
                bus.line_valid = 1'b1;
                bus.line_data  = bus.buf_line;
                bus.line_addr  = line_addr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed bench for line_fill_ctrl (BEATS=8, TIMEOUT=4): cycle table plus a data-path sequence.
module tb_line_fill_ctrl;
    import line_fill_ctrl_pkg::*;

    logic dramclk = 1'b0;
    logic reset   = 1'b1;
    always #5 dramclk = ~dramclk;

    line_fill_ctrl_if bif();

    line_fill_ctrl #(.BEATS(8), .TIMEOUT(4)) dut (
        .dramclk (dramclk),
        .reset   (reset),
        .bus     (bif)
    );

    // External read line buffer: newest word enters at the top.
    logic [WORD_BITS-1:0] word = '0;
    logic [LINE_BITS-1:0] lbuf = '0;
    always @(posedge dramclk)
        if (bif.buf_we) lbuf <= {word, lbuf[LINE_BITS-1:WORD_BITS]};
    assign bif.buf_line = lbuf;

    typedef struct packed {
        logic        ack;
        logic        cmd;
        logic [31:0] daddr;
        logic        we;
        logic        lv;
        logic [31:0] laddr;
        logic        busy;
        logic        err;
    } outs_t;

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        cack;
        logic        dv;
        logic        lrdy;
        outs_t       exp;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;

    function automatic outs_t o(input logic ack, cmd, input logic [31:0] daddr,
                                input logic we, lv, input logic [31:0] laddr,
                                input logic busy, err);
        outs_t r;
        r = '{ack, cmd, daddr, we, lv, laddr, busy, err};
        return r;
    endfunction

    task automatic add(input int n, input logic rst, req, input logic [31:0] addr,
                       input logic cack, dv, lrdy, input outs_t e);
        vec_t t;
        t = '{rst, req, addr, cack, dv, lrdy, e};
        for (int k = 0; k < n; k++) tv.push_back(t);
    endtask

    task automatic cyc(input logic rst, req, input logic [31:0] addr,
                       input logic cack, dv, lrdy, input logic [31:0] wd);
        @(negedge dramclk);
        reset            = rst;
        bif.req          = req;
        bif.req_addr     = addr;
        bif.dram_cmd_ack = cack;
        bif.dram_valid   = dv;
        bif.line_ready   = lrdy;
        word             = wd;
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    outs_t                idle0, cmdo, fillwe, fillq;
    outs_t                act;
    logic [31:0]          w [8];
    int                   gap [8];
    logic [LINE_BITS-1:0] exp_line;
    int                   we_cnt;

    initial begin
        bif.req = 0; bif.req_addr = '0; bif.dram_cmd_ack = 0;
        bif.dram_valid = 0; bif.line_ready = 0;

        idle0  = o(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        fillwe = o(0, 0, 32'h0, 1, 0, 32'h0, 1, 0);
        fillq  = o(0, 0, 32'h0, 0, 0, 32'h0, 1, 0);

        // reset state, with active inputs that must be ignored
        add(1, 1, 1, 32'h0000_1234, 1, 1, 1, idle0);
        add(1, 1, 0, 32'h0,         0, 0, 0, idle0);
        // basic fill: CMD_ACK on 3rd CMD cycle, 8 back-to-back beats
        add(1, 0, 1, 32'h0000_1234, 0, 0, 0, idle0);
        add(1, 0, 0, 32'h0,         0, 0, 0, o(1, 1, 32'h0000_1220, 0, 0, 32'h0, 1, 0));
        add(1, 0, 0, 32'h0,         0, 1, 0, o(0, 1, 32'h0000_1220, 0, 0, 32'h0, 1, 0));
        add(1, 0, 0, 32'h0,         1, 0, 0, o(0, 1, 32'h0000_1220, 0, 0, 32'h0, 1, 0));
        add(8, 0, 0, 32'h0,         0, 1, 0, fillwe);
        add(1, 0, 0, 32'h0,         0, 1, 0, o(0, 0, 32'h0, 0, 1, 32'h0000_1220, 1, 0));
        add(1, 0, 0, 32'h0,         0, 0, 1, o(0, 0, 32'h0, 0, 1, 32'h0000_1220, 1, 0));
        add(1, 0, 0, 32'h0,         0, 1, 1, idle0);
        // second request while busy, then held high into IDLE
        add(1, 0, 1, 32'h8000_207F, 0, 0, 0, idle0);
        add(1, 0, 0, 32'h0,         1, 0, 0, o(1, 1, 32'h8000_2060, 0, 0, 32'h0, 1, 0));
        add(8, 0, 1, 32'hFFFF_FFFF, 0, 1, 0, fillwe);
        add(1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, o(0, 0, 32'h0, 0, 1, 32'h8000_2060, 1, 0));
        add(1, 0, 1, 32'h0000_0040, 0, 0, 1, o(0, 0, 32'h0, 0, 1, 32'h8000_2060, 1, 0));
        add(1, 0, 1, 32'h0000_0040, 0, 0, 0, idle0);
        add(1, 0, 0, 32'h0,         1, 0, 0, o(1, 1, 32'h0000_0040, 0, 0, 32'h0, 1, 0));
        // timeout: 3 beats, ERR on the 4th silent cycle
        add(3, 0, 0, 32'h0,         0, 1, 0, fillwe);
        add(3, 0, 0, 32'h0,         0, 0, 0, fillq);
        add(1, 0, 0, 32'h0,         0, 0, 0, o(0, 0, 32'h0, 0, 0, 32'h0, 1, 1));
        add(1, 0, 0, 32'h0,         0, 1, 1, idle0);
        add(1, 0, 0, 32'h0,         0, 0, 0, idle0);
        // reset after beat 5, no ERR, then a normal request
        add(1, 0, 1, 32'h0000_5555, 0, 0, 0, idle0);
        add(1, 0, 0, 32'h0,         1, 0, 0, o(1, 1, 32'h0000_5540, 0, 0, 32'h0, 1, 0));
        add(5, 0, 0, 32'h0,         0, 1, 0, fillwe);
        add(1, 1, 1, 32'h0000_9999, 1, 1, 1, idle0);
        add(1, 0, 0, 32'h0,         0, 0, 0, idle0);
        add(1, 0, 1, 32'h0000_ABCD, 0, 0, 0, idle0);
        add(1, 0, 0, 32'h0,         1, 0, 0, o(1, 1, 32'h0000_ABC0, 0, 0, 32'h0, 1, 0));
        // gaps; beat on the would-expire cycle counts and suppresses ERR
        add(1, 0, 0, 32'h0,         0, 1, 0, fillwe);
        add(3, 0, 0, 32'h0,         0, 0, 0, fillq);
        add(3, 0, 0, 32'h0,         0, 1, 0, fillwe);
        add(1, 0, 0, 32'h0,         0, 0, 0, fillq);
        add(3, 0, 0, 32'h0,         0, 1, 0, fillwe);
        add(2, 0, 0, 32'h0,         0, 0, 0, fillq);
        add(1, 0, 0, 32'h0,         0, 1, 0, fillwe);
        add(1, 0, 0, 32'h0,         0, 0, 1, o(0, 0, 32'h0, 0, 1, 32'h0000_ABC0, 1, 0));
        add(1, 0, 0, 32'h0,         0, 0, 0, idle0);

        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].rst, tv[i].req, tv[i].addr, tv[i].cack, tv[i].dv, tv[i].lrdy,
                32'h1000_0000 + i);
            act = '{bif.req_ack, bif.dram_cmd, bif.dram_addr, bif.buf_we, bif.line_valid,
                    bif.line_addr, bif.busy, bif.err};
            chk($sformatf("row%0d", i), 256'(act), 256'(tv[i].exp));
            if (tv[i].rst) chk($sformatf("row%0d_rst_data", i), bif.line_data, '0);
        end

        // line data path: gapped beats, line held 5 cycles without LINE_READY
        gap = '{0, 2, 3, 1, 0, 3, 2, 0};
        for (int i = 0; i < 8; i++) w[i] = 32'hC0DE_0000 + 32'(i * 17 + 3);
        for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = w[i];
        we_cnt = 0;
        cyc(0, 1, 32'h0000_301C, 0, 0, 0, 32'h0);
        cyc(0, 0, 32'h0,         1, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                cyc(0, 0, 32'h0, 0, 0, 0, 32'hDEAD_BEEF);
                if (bif.buf_we) we_cnt++;
            end
            cyc(0, 0, 32'h0, 0, 1, 0, w[i]);
            if (bif.buf_we) we_cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 32'h0, 0, 0, 0, 32'h0);
            chk($sformatf("hold%0d_valid", k), 256'(bif.line_valid), 256'(1));
            chk($sformatf("hold%0d_data", k),  bif.line_data, exp_line);
            chk($sformatf("hold%0d_addr", k),  256'(bif.line_addr), 256'(32'h0000_3000));
        end
        chk("we_pulses", 256'(we_cnt), 256'(8));
        cyc(0, 0, 32'h0, 0, 0, 1, 32'h0);
        chk("take_data", bif.line_data, exp_line);
        cyc(0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("after_busy",  256'(bif.busy), 256'(0));
        chk("after_valid", 256'(bif.line_valid), 256'(0));
        chk("after_data",  bif.line_data, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_fill_ctrl.md
LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

Interface
REQ-001 SHALL have parameter BEATS, default 8, meaning DRAM data beats per line (32-bit words).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum idle cycles allowed between beats in FILL.
REQ-003 SHALL have port DRAMCLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port REQ  input  1  cache miss fill request.
REQ-006 SHALL have port REQ_ADDR  input  32  miss byte address.
REQ-007 SHALL have port REQ_ACK  output  1  one-cycle pulse when a request is accepted.
REQ-008 SHALL have port DRAM_CMD  output  1  read-burst command to DRAM controller.
REQ-009 SHALL have port DRAM_ADDR  output  32  line-aligned burst address.
REQ-010 SHALL have port DRAM_CMD_ACK  input  1  DRAM controller accepted command.
REQ-011 SHALL have port DRAM_VALID  input  1  one 32-bit read beat present this cycle.
REQ-012 SHALL have port BUF_WE  output  1  shift enable to the 256-bit read line buffer.
REQ-013 SHALL have port BUF_LINE  input  256  assembled line from the read line buffer.
REQ-014 SHALL have port LINE_VALID  output  1  filled line available to cache.
REQ-015 SHALL have port LINE_DATA  output  256  filled line data.
REQ-016 SHALL have port LINE_ADDR  output  32  filled line address.
REQ-017 SHALL have port LINE_READY  input  1  cache consumes line.
REQ-018 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-019 SHALL have port ERR  output  1  one-cycle pulse on beat timeout.

Function
REQ-020 SHALL implement FSM states IDLE, CMD, FILL, DELIVER.
REQ-021 IDLE with REQ=1 at an edge SHALL latch {REQ_ADDR[31:5],5'b0} as line address, pulse REQ_ACK for the following cycle, and go to CMD.
REQ-022 CMD SHALL hold DRAM_CMD=1 with DRAM_ADDR=line address until DRAM_CMD_ACK=1 is sampled, then go to FILL with beat count 0 and the timer cleared; CMD has no timeout.
REQ-023 FILL SHALL drive BUF_WE = DRAM_VALID combinationally; BUF_WE SHALL be 0 in all other states.
REQ-024 Each edge sampling DRAM_VALID=1 in FILL SHALL increment the beat count (width $clog2(BEATS)+1) and clear the timer.
REQ-025 The edge sampling beat BEATS SHALL move to DELIVER; extra DRAM_VALID beats outside FILL SHALL be ignored.
REQ-026 DELIVER SHALL assert LINE_VALID=1, LINE_DATA=BUF_LINE (pass-through; stable because BUF_WE=0), and LINE_ADDR=latched address, and SHALL hold them until LINE_READY=1 is sampled, then return to IDLE.
REQ-027 LINE_READY=1 outside DELIVER SHALL have no effect.
REQ-028 The latency from the edge sampling the last beat to LINE_VALID=1 SHALL be 1 cycle.
REQ-029 FILL SHALL increment the timer on each cycle without DRAM_VALID; reaching TIMEOUT SHALL pulse ERR for one cycle, discard the partial line, and return to IDLE.
REQ-030 REQ in any state other than IDLE SHALL be ignored with no REQ_ACK; a request held high into IDLE SHALL be accepted on the first IDLE edge.
REQ-031 DRAM_VALID and the timeout condition on the same edge SHALL count the beat; no timeout occurs.

Reset
REQ-032 RESET=1 SHALL immediately force IDLE, beat count 0, timer 0, and address 0.
REQ-033 While RESET=1, all outputs SHALL be 0: REQ_ACK, DRAM_CMD, DRAM_ADDR, BUF_WE, LINE_VALID, LINE_DATA, LINE_ADDR, BUSY, ERR.
REQ-034 Reset asserted mid-FILL or mid-DELIVER SHALL abandon the fill with no ERR pulse.

Structure
REQ-035 A shared package SHALL hold the state encoding, LINE_BITS=256, WORD_BITS=32, and LINE_OFFSET_BITS=5.
REQ-036 The timeout counter SHALL be one sub-module, fill_timer, with clear, enable, and expired ports.

Verification
REQ-037 REQ=1 with REQ_ADDR=0x0000_1234, CMD_ACK after 3 cycles, then 8 back-to-back beats -> REQ_ACK pulse, DRAM_ADDR=0x0000_1220, 8 BUF_WE pulses, LINE_VALID 1 cycle after the 8th beat, LINE_ADDR=0x0000_1220.
REQ-038 Beats with 0-3 gap cycles, LINE_READY held low for 5 cycles -> LINE_VALID and LINE_DATA stable all 5 cycles, then IDLE and BUSY=0.
REQ-039 TIMEOUT=4, 3 beats then silence -> ERR pulse on the 4th idle cycle, return to IDLE, LINE_VALID never asserted.
REQ-040 Second REQ during FILL, DRAM_VALID asserted in IDLE -> no REQ_ACK, BUF_WE stays 0, beat count unaffected.
REQ-041 RESET pulsed after beat 5 -> all outputs 0 immediately, no ERR; a new request then completes normally.
